// File: rtl/mseq_pkg.sv
// Shared opcodes and microword field-position helpers for the microsequencer.
package mseq_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] OP_DECODE = 3'd0;
   localparam logic [OP_W-1:0] OP_CONT   = 3'd1;
   localparam logic [OP_W-1:0] OP_JUMP   = 3'd2;
   localparam logic [OP_W-1:0] OP_CJUMP  = 3'd3;
   localparam logic [OP_W-1:0] OP_WAIT   = 3'd4;
   localparam logic [OP_W-1:0] OP_CALL   = 3'd5;
   localparam logic [OP_W-1:0] OP_RET    = 3'd6;
   localparam logic [OP_W-1:0] OP_CRET   = 3'd7;

   // Condition-select width; never below one bit so the field always exists.
   function automatic int sel_width(input int ncond);
      return (ncond <= 2) ? 1 : $clog2(ncond);
   endfunction

   // Field positions, counted down from the top of the microword.
   function automatic int op_msb(input int word_w);
      return word_w - 1;
   endfunction

   function automatic int inv_bit(input int word_w);
      return word_w - 4;
   endfunction

   function automatic int sel_msb(input int word_w);
      return word_w - 5;
   endfunction

   // Smallest microword that still holds OP, INV, SEL and TGT without overlap.
   function automatic int min_word_w(input int addr_w, input int sel_w);
      return 4 + sel_w + addr_w;
   endfunction

   // Stack pointer must be able to hold STACK_DEPTH itself (the full state).
   function automatic int sp_width(input int depth);
      return (depth < 1) ? 1 : $clog2(depth + 1);
   endfunction

   // Entry index width for the stack storage array.
   function automatic int idx_width(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/mseq_stack.sv
// Return-address LIFO for microsubroutine CALL/RET. Push when full and pop
// when empty are ignored here; the caller raises the sticky error flags.
module mseq_stack
   import mseq_pkg::*;
#(
   parameter int ADDR_W      = 7,
   parameter int STACK_DEPTH = 4
) (
   input  logic              Clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] din,
   output logic [ADDR_W-1:0] dout,
   output logic              full,
   output logic              empty
);

   localparam int SP_W  = sp_width(STACK_DEPTH);
   localparam int IDX_W = idx_width(STACK_DEPTH);

   logic [ADDR_W-1:0] r_mem [0:STACK_DEPTH-1];
   logic [SP_W-1:0]   r_sp;
   logic [IDX_W-1:0]  w_wr_idx;
   logic [IDX_W-1:0]  w_top_idx;

   assign full      = (r_sp == SP_W'(STACK_DEPTH));
   assign empty     = (r_sp == '0);
   assign w_wr_idx  = IDX_W'(r_sp);
   assign w_top_idx = IDX_W'(r_sp - 1'b1);
   assign dout      = empty ? '0 : r_mem[w_top_idx];

   // Pointer update and entry write; entries need no reset since sp gates them.
   always_ff @(posedge Clk) begin
      if (reset) begin
         r_sp <= '0;
      end else if (push && !full) begin
         r_mem[w_wr_idx] <= din;
         r_sp            <= r_sp + 1'b1;
      end else if (pop && !empty) begin
         r_sp <= r_sp - 1'b1;
      end
   end

endmodule

// File: rtl/microsequencer_stack.sv
// Microprogrammed control sequencer: writable microstore, registered
// state/control word, conditional next-address logic and a CALL/RET stack.
module microsequencer_stack
   import mseq_pkg::*;
#(
   parameter int ADDR_W      = 7,
   parameter int WORD_W      = 33,
   parameter int NCOND       = 4,
   parameter int STACK_DEPTH = 4
) (
   input  logic              Clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] decode_addr,
   input  logic [NCOND-1:0]  cond_in,
   input  logic              ms_we,
   input  logic [ADDR_W-1:0] ms_waddr,
   input  logic [WORD_W-1:0] ms_wdata,
   output logic [ADDR_W-1:0] state,
   output logic [WORD_W-1:0] ctrl,
   output logic              stack_ovf,
   output logic              stack_unf
);

   localparam int SEL_W   = sel_width(NCOND);
   localparam int DEPTH   = 2 ** ADDR_W;
   localparam int OP_MSB  = op_msb(WORD_W);
   localparam int INV_BIT = inv_bit(WORD_W);
   localparam int SEL_MSB = sel_msb(WORD_W);

   generate
      if (WORD_W < min_word_w(ADDR_W, SEL_W)) begin : g_word_w_check
         $error("microsequencer_stack: WORD_W too small for OP/INV/SEL/TGT fields");
      end
   endgenerate

   logic [WORD_W-1:0] r_mem [0:DEPTH-1];
   logic [ADDR_W-1:0] r_state;
   logic [WORD_W-1:0] r_ctrl;
   logic              r_ovf;
   logic              r_unf;

   logic [OP_W-1:0]   w_op;
   logic              w_inv;
   logic [SEL_W-1:0]  w_sel;
   logic [ADDR_W-1:0] w_tgt;
   logic [ADDR_W-1:0] w_inc;
   logic              w_cond_raw;
   logic              w_cond;
   logic [ADDR_W-1:0] w_next;
   logic              w_push;
   logic              w_pop;
   logic [ADDR_W-1:0] w_pop_addr;
   logic              w_full;
   logic              w_empty;

   assign w_op  = r_ctrl[OP_MSB -: OP_W];
   assign w_inv = r_ctrl[INV_BIT];
   assign w_sel = r_ctrl[SEL_MSB -: SEL_W];
   assign w_tgt = r_ctrl[ADDR_W-1:0];
   assign w_inc = r_state + 1'b1;   // wraps at the top of the microstore

   // Condition mux; selects past the last input read as 0 before inversion.
   always_comb begin
      w_cond_raw = 1'b0;
      if (int'(w_sel) < NCOND) w_cond_raw = cond_in[w_sel];
   end

   assign w_cond = w_cond_raw ^ w_inv;

   // Next-address mux plus stack requests for the current microword.
   always_comb begin
      w_next = w_inc;
      w_push = 1'b0;
      w_pop  = 1'b0;
      case (w_op)
         OP_DECODE: w_next = decode_addr;
         OP_CONT:   w_next = w_inc;
         OP_JUMP:   w_next = w_tgt;
         OP_CJUMP:  w_next = w_cond ? w_tgt : w_inc;
         OP_WAIT:   w_next = w_cond ? w_inc : r_state;
         OP_CALL: begin
            w_next = w_tgt;   // jump is taken even when the push is dropped
            w_push = 1'b1;
         end
         OP_RET: begin
            w_next = w_empty ? '0 : w_pop_addr;
            w_pop  = 1'b1;
         end
         OP_CRET: begin
            if (w_cond) begin
               w_next = w_empty ? '0 : w_pop_addr;
               w_pop  = 1'b1;
            end
         end
         default: w_next = w_inc;
      endcase
   end

   mseq_stack #(
      .ADDR_W      (ADDR_W),
      .STACK_DEPTH (STACK_DEPTH)
   ) u_stack (
      .Clk   (Clk),
      .reset (reset),
      .push  (w_push),
      .pop   (w_pop),
      .din   (w_inc),
      .dout  (w_pop_addr),
      .full  (w_full),
      .empty (w_empty)
   );

   // Microstore write port; reset does not block loading.
   always_ff @(posedge Clk) begin
      if (ms_we) r_mem[ms_waddr] <= ms_wdata;
   end

   // State and control register; a same-cycle write to the fetched address
   // is not forwarded, so ctrl takes the old word.
   always_ff @(posedge Clk) begin
      if (reset) begin
         r_state <= '0;
         r_ctrl  <= r_mem[0];
      end else begin
         r_state <= w_next;
         r_ctrl  <= r_mem[w_next];
      end
   end

   // Sticky stack error flags, cleared only by reset.
   always_ff @(posedge Clk) begin
      if (reset) begin
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         if (w_push && w_full)  r_ovf <= 1'b1;
         if (w_pop  && w_empty) r_unf <= 1'b1;
      end
   end

   assign state     = r_state;
   assign ctrl      = r_ctrl;
   assign stack_ovf = r_ovf;
   assign stack_unf = r_unf;

endmodule

// File: tb/tb_microsequencer_stack.sv
// Directed bench: loads a microprogram, steps a vector table through it and
// finishes with hand-written reset and write-collision sequences.
module tb_microsequencer_stack;

   localparam logic [2:0] DEC = 3'd0, CON = 3'd1, JMP = 3'd2, CJP = 3'd3;
   localparam logic [2:0] WAI = 3'd4, CAL = 3'd5, RET = 3'd6, CRT = 3'd7;

   logic        Clk = 1'b0;
   logic        reset;
   logic [6:0]  decode_addr;
   logic [3:0]  cond_in;
   logic        ms_we;
   logic [6:0]  ms_waddr;
   logic [32:0] ms_wdata;
   logic [6:0]  state;
   logic [32:0] ctrl;
   logic        stack_ovf;
   logic        stack_unf;

   microsequencer_stack #(
      .ADDR_W(7), .WORD_W(33), .NCOND(4), .STACK_DEPTH(4)
   ) dut (
      .Clk(Clk), .reset(reset), .decode_addr(decode_addr), .cond_in(cond_in),
      .ms_we(ms_we), .ms_waddr(ms_waddr), .ms_wdata(ms_wdata),
      .state(state), .ctrl(ctrl), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [6:0] dec;
      logic [3:0] cond;
      logic [6:0] exp_state;
      logic       exp_ovf;
      logic       exp_unf;
   } vec_t;

   vec_t        vecs [0:38];
   logic [32:0] model [0:127];
   int          checks = 0;
   int          errors = 0;
   int          nv = 0;

   function automatic logic [32:0] mw(input logic [2:0] op, input logic inv,
                                      input logic [1:0] sel, input logic [6:0] tgt,
                                      input logic [6:0] addr);
      logic [32:0] w;
      w        = '0;
      w[32:30] = op;
      w[29]    = inv;
      w[28:27] = sel;
      w[26:7]  = {13'h1A5, addr};
      w[6:0]   = tgt;
      return w;
   endfunction

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [2:0] op, input logic inv, input logic [1:0] sel,
                     input logic [6:0] tgt, input logic [6:0] addr);
      ms_we    = 1'b1;
      ms_waddr = addr;
      ms_wdata = mw(op, inv, sel, tgt, addr);
      model[addr] = ms_wdata;
      step();
      ms_we = 1'b0;
   endtask

   task automatic addv(input logic [6:0] dec, input logic [3:0] cond,
                       input logic [6:0] st, input logic ovf, input logic unf);
      vecs[nv].dec       = dec;
      vecs[nv].cond      = cond;
      vecs[nv].exp_state = st;
      vecs[nv].exp_ovf   = ovf;
      vecs[nv].exp_unf   = unf;
      nv++;
   endtask

   task automatic chk_all(input string tag, input logic [6:0] st,
                          input logic ovf, input logic unf);
      chk({tag, " state"}, 64'(state), 64'(st));
      chk({tag, " ctrl"}, 64'(ctrl), 64'(model[st]));
      chk({tag, " ovf"}, 64'(stack_ovf), 64'(ovf));
      chk({tag, " unf"}, 64'(stack_unf), 64'(unf));
   endtask

   logic [32:0] old_w;
   logic [32:0] new_w;

   initial begin
      reset = 1'b1; decode_addr = '0; cond_in = '0;
      ms_we = 1'b0; ms_waddr = '0; ms_wdata = '0;
      for (int i = 0; i < 128; i++) model[i] = '0;

      // Program loaded while reset is held.
      wr(CON,0,0,0,0);    wr(CON,0,0,0,1);    wr(CON,0,0,0,2);   wr(DEC,0,0,0,3);
      wr(JMP,0,0,11,5);   wr(WAI,0,0,0,11);   wr(WAI,1,0,0,12);  wr(JMP,0,0,20,13);
      wr(CJP,0,1,40,20);  wr(JMP,0,0,60,40);  wr(CJP,1,1,40,60); wr(CJP,1,1,70,61);
      wr(JMP,0,0,127,70); wr(CON,0,0,0,127);
      wr(CAL,0,0,90,8);   wr(RET,0,0,0,90);   wr(CAL,0,0,91,9);
      wr(CRT,0,2,0,91);   wr(CRT,0,2,0,92);   wr(JMP,0,0,100,10);
      wr(CAL,0,0,102,100); wr(CAL,0,0,104,102); wr(CAL,0,0,106,104);
      wr(CAL,0,0,108,106); wr(CAL,0,0,110,108);
      wr(RET,0,0,0,110);  wr(RET,0,0,0,107);  wr(RET,0,0,0,105);
      wr(RET,0,0,0,103);  wr(RET,0,0,0,101);  wr(CON,0,0,0,50);

      step(); step();
      chk_all("reset", 7'd0, 1'b0, 1'b0);
      reset = 1'b0;

      addv(0,0,1,0,0);       addv(0,0,2,0,0);       addv(0,0,3,0,0);
      addv(5,0,5,0,0);       addv(0,0,11,0,0);                        // decode, jump
      addv(0,0,11,0,0);      addv(0,0,11,0,0);      addv(0,0,11,0,0); // wait stall
      addv(0,4'b0001,12,0,0);                                         // MOC arrives
      addv(0,4'b0001,12,0,0); addv(0,0,13,0,0);                       // inverted wait
      addv(0,0,20,0,0);      addv(0,4'b0010,40,0,0);                  // cjump taken
      addv(0,0,60,0,0);      addv(0,4'b0010,61,0,0);                  // inv, not taken
      addv(0,0,70,0,0);      addv(0,0,127,0,0);     addv(0,0,0,0,0);  // inv taken, wrap
      addv(0,0,1,0,0);       addv(0,0,2,0,0);       addv(0,0,3,0,0);
      addv(8,0,8,0,0);       addv(0,0,90,0,0);      addv(0,0,9,0,0);  // call/ret
      addv(0,0,91,0,0);      addv(0,0,92,0,0);                        // cret false
      addv(0,4'b0100,10,0,0); addv(0,0,100,0,0);                      // cret true
      addv(0,0,102,0,0);     addv(0,0,104,0,0);     addv(0,0,106,0,0);
      addv(0,0,108,0,0);     addv(0,0,110,1,0);                       // 5th call
      addv(0,0,107,1,0);     addv(0,0,105,1,0);     addv(0,0,103,1,0);
      addv(0,0,101,1,0);     addv(0,0,0,1,1);       addv(0,0,1,1,1);  // underflow

      for (int i = 0; i < nv; i++) begin
         decode_addr = vecs[i].dec;
         cond_in     = vecs[i].cond;
         step();
         chk_all($sformatf("vec%0d", i), vecs[i].exp_state, vecs[i].exp_ovf, vecs[i].exp_unf);
      end
      decode_addr = '0; cond_in = '0;

      // Reset mid-sequence with both flags set.
      step();
      reset = 1'b1;
      step();
      chk_all("midreset", 7'd0, 1'b0, 1'b0);
      reset = 1'b0;

      // Write to address 1 in the cycle that fetches it.
      old_w    = model[1];
      new_w    = mw(JMP, 0, 0, 50, 7'd1);
      ms_we    = 1'b1;
      ms_waddr = 7'd1;
      ms_wdata = new_w;
      step();
      ms_we = 1'b0;
      chk("collide state", 64'(state), 64'd1);
      chk("collide ctrl old", 64'(ctrl), 64'(old_w));
      model[1] = new_w;
      step();
      chk("collide old exec", 64'(state), 64'd2);
      step();
      decode_addr = 7'd1;
      step();
      decode_addr = '0;
      chk("refetch state", 64'(state), 64'd1);
      chk("refetch ctrl new", 64'(ctrl), 64'(new_w));
      step();
      chk("new word exec", 64'(state), 64'd50);
      chk("new word ctrl", 64'(ctrl), 64'(model[50]));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
